// File: rtl/wt_cache_pkg.sv
// wt_cache_pkg: shared types for the cache read-port arbiter
package wt_cache_pkg;
  localparam int unsigned MaxAddrWidth = 64;
  localparam int unsigned MaxBlenWidth = 8;
  typedef enum logic {IDLE, HOLD} arb_state_e;
  typedef struct packed {
    logic [MaxAddrWidth-1:0] addr;
    logic [MaxBlenWidth-1:0] blen;
    logic [2:0]              size;
  } rd_req_t;
endpackage

// File: rtl/rr_arb_tree.sv
// rr_arb_tree: round-robin picker from an external pointer, optionally locking an unaccepted pick
module rr_arb_tree #(
  parameter int unsigned NumIn = 2,
  parameter bit LockIn = 1'b1,
  localparam int unsigned IdxWidth = $clog2(NumIn)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [IdxWidth-1:0] rr_i,
  input  logic [NumIn-1:0]    req_i,
  input  logic                gnt_i,
  output logic                req_o,
  output logic [IdxWidth-1:0] idx_o
);
  logic lock_q, found;
  logic [IdxWidth-1:0] lock_idx_q, pick, c;
  always_comb begin
    pick = '0;
    c = '0;
    found = 1'b0;
    req_o = |req_i;
    for (int i = 0; i < NumIn; i++) begin
      c = IdxWidth'((int'(rr_i) + i) % int'(NumIn));
      if (!found && req_i[c]) begin
        pick = c;
        found = 1'b1;
      end
    end
    idx_o = (LockIn && lock_q) ? lock_idx_q : pick;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q <= req_o && !gnt_i;
      if (req_o && !gnt_i && !lock_q) lock_idx_q <= idx_o;
    end
  end
endmodule

// File: rtl/axi_rd_port_arbiter.sv
// axi_rd_port_arbiter: round-robin share of one AXI read channel, with per-port return routing by ID
module axi_rd_port_arbiter
  import wt_cache_pkg::*;
#(
  parameter int unsigned NumPorts = 2,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiIdWidth = 4,
  parameter int unsigned BlenWidth = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumPorts-1:0]                  req_i,
  output logic [NumPorts-1:0]                  gnt_o,
  input  logic [NumPorts-1:0][AxiAddrWidth-1:0] addr_i,
  input  logic [NumPorts-1:0][BlenWidth-1:0]   blen_i,
  input  logic [NumPorts-1:0][2:0]             size_i,
  output logic                                 rd_req_o,
  output logic [AxiAddrWidth-1:0]              rd_addr_o,
  output logic [BlenWidth-1:0]                 rd_blen_o,
  output logic [2:0]                           rd_size_o,
  output logic [AxiIdWidth-1:0]                rd_id_o,
  input  logic                                 rd_gnt_i,
  input  logic                                 rd_valid_i,
  input  logic                                 rd_last_i,
  input  logic [AxiDataWidth-1:0]              rd_data_i,
  input  logic [AxiIdWidth-1:0]                rd_id_i,
  output logic [NumPorts-1:0]                  rtrn_valid_o,
  output logic                                 rtrn_last_o,
  output logic [AxiDataWidth-1:0]              rtrn_data_o,
  output logic [NumPorts-1:0]                  busy_o,
  output logic                                 err_o
);
  localparam int unsigned IdxWidth = $clog2(NumPorts);
  arb_state_e state_q;
  logic [IdxWidth-1:0] ptr_q, hold_q, arb_idx, winner, id;
  logic [NumPorts-1:0] busy_q;
  logic arb_req, grant, route;
  rd_req_t [NumPorts-1:0] reqs;
  rd_req_t sel;
  always_comb begin
    for (int i = 0; i < NumPorts; i++)
      reqs[i] = '{addr: MaxAddrWidth'(addr_i[i]), blen: MaxBlenWidth'(blen_i[i]), size: size_i[i]};
  end
  rr_arb_tree #(.NumIn(NumPorts), .LockIn(1'b1)) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rr_i  (ptr_q),
    .req_i (req_i & ~busy_q),
    .gnt_i (rd_gnt_i),
    .req_o (arb_req),
    .idx_o (arb_idx)
  );
  assign winner = state_q == HOLD ? hold_q : arb_idx;
  assign sel = reqs[winner];
  assign rd_req_o = !rst_i && (state_q == HOLD || arb_req);
  assign rd_addr_o = AxiAddrWidth'(sel.addr);
  assign rd_blen_o = BlenWidth'(sel.blen);
  assign rd_size_o = sel.size;
  assign rd_id_o = AxiIdWidth'(winner);
  assign grant = rd_req_o && rd_gnt_i;
  assign gnt_o = grant ? NumPorts'(1) << winner : '0;
  assign id = rd_id_i[IdxWidth-1:0];
  assign route = rd_valid_i && !rst_i && 32'(rd_id_i) < NumPorts && busy_q[id];
  assign rtrn_valid_o = route ? NumPorts'(1) << id : '0;
  assign rtrn_last_o = rd_last_i;
  assign rtrn_data_o = rd_data_i;
  assign err_o = rd_valid_i && !rst_i && !route;
  assign busy_o = busy_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q <= '0;
      hold_q <= '0;
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~(rd_last_i ? rtrn_valid_o : '0)) | gnt_o;
      if (grant) begin
        state_q <= IDLE;
        ptr_q <= winner == IdxWidth'(NumPorts - 1) ? '0 : winner + 1'b1;
      end else if (rd_req_o) begin
        state_q <= HOLD;
        hold_q <= winner;
      end
    end
  end
endmodule

// File: doc/axi_rd_port_arbiter.md
AXI_RD_PORT_ARBITER -- requirements
Module: axi_rd_port_arbiter

Interface
REQ-001 SHALL have parameter NumPorts, default 2: number of read requesters (L1I$ refill, prefetch, ...); legal range 2..8.
REQ-002 SHALL have parameter AxiAddrWidth, default 64: read address width.
REQ-003 SHALL have parameter AxiDataWidth, default 64: return beat width.
REQ-004 SHALL have parameter AxiIdWidth, default 4: transaction ID width; must satisfy 2**AxiIdWidth >= NumPorts.
REQ-005 SHALL have parameter BlenWidth, default 2: burst length field width (beats-1).
REQ-006 SHALL have port clk_i  in  1  the single clock; all logic on rising edge.
REQ-007 SHALL have port rst_i  in  1  synchronous, active-high reset.
REQ-008 SHALL have port req_i  in  NumPorts  per-requester read request.
REQ-009 SHALL have port gnt_o  out  NumPorts  per-requester grant, one-cycle pulse.
REQ-010 SHALL have port addr_i  in  NumPorts x AxiAddrWidth  request address.
REQ-011 SHALL have port blen_i  in  NumPorts x BlenWidth  burst length-1.
REQ-012 SHALL have port size_i  in  NumPorts x 3  beat size (log2 bytes).
REQ-013 SHALL have port rd_req_o / rd_addr_o / rd_blen_o / rd_size_o / rd_id_o  out  1/AxiAddrWidth/BlenWidth/3/AxiIdWidth  request to axi_shim read channel.
REQ-014 SHALL have port rd_gnt_i  in  1  axi_shim grant.
REQ-015 SHALL have port rd_valid_i / rd_last_i / rd_data_i / rd_id_i  in  1/1/AxiDataWidth/AxiIdWidth  return beats from axi_shim.
REQ-016 SHALL have port rtrn_valid_o  out  NumPorts  per-requester beat valid.
REQ-017 SHALL have port rtrn_last_o / rtrn_data_o  out  1/AxiDataWidth  shared beat last flag and data.
REQ-018 SHALL have port busy_o  out  NumPorts  requester has a transaction outstanding.
REQ-019 SHALL have port err_o  out  1  one-cycle pulse on an unroutable return beat.

Function
REQ-020 SHALL require requesters to hold req_i and their addr/blen/size stable until gnt_o; the arbiter does not buffer request fields.
REQ-021 SHALL allow at most one outstanding transaction per port; a port is eligible iff req_i=1 and busy_o=0.
REQ-022 SHALL implement FSM {IDLE, HOLD}: in IDLE it picks the round-robin winner among eligible ports, starting at pointer ptr_q, and drives rd_req_o=1 with the winner's fields in the same cycle (zero-cycle latency).
REQ-023 SHALL, on rd_gnt_i=1 in either state: pulse gnt_o[winner], set busy[winner], set ptr_q to winner+1 (wrapping NumPorts-1 to 0), and go to or remain in IDLE.
REQ-024 SHALL, on a request not granted in IDLE, latch the winner and enter HOLD; in HOLD it keeps rd_req_o=1 with the latched port's fields and SHALL NOT re-arbitrate until rd_gnt_i (AXI stability).
REQ-025 SHALL drive rd_id_o equal to the winner index, zero-extended to AxiIdWidth.
REQ-026 SHALL route return beats combinationally: when rd_valid_i=1, rd_id_i<NumPorts and busy[rd_id_i]=1, assert rtrn_valid_o[rd_id_i]; rtrn_data_o=rd_data_i and rtrn_last_o=rd_last_i at all times.
REQ-027 SHALL clear busy[id] at the end of the cycle carrying rd_last_i for that id.
REQ-028 SHALL make a port whose last beat and new req_i coincide eligible only from the next cycle.
REQ-029 SHALL, on a beat with rd_id_i>=NumPorts or with busy[rd_id_i]=0, assert no rtrn_valid_o, drop the beat and pulse err_o.
REQ-030 SHALL make grants and return beats to different ports in the same cycle independent of each other.

Reset
REQ-031 SHALL, with rst_i=1 at a clock edge, set FSM=IDLE, ptr_q=0 and busy=0; gnt_o, rd_req_o, rtrn_valid_o and err_o are 0 while rst_i=1.
REQ-032 SHALL, after a reset mid-burst, treat residual beats as unroutable (REQ-029).

Structure
REQ-033 SHALL place the arbiter FSM state enum and the per-port request struct (addr, blen, size) in wt_cache_pkg.
REQ-034 SHALL use a single sub-module, common_cells rr_arb_tree with LockIn=1, for winner selection; the FSM and busy tracking stay in this module.

Verification
REQ-035 SHALL verify: req_i=2'b11 from reset with rd_gnt_i=1 -> port0 granted with rd_id_o=0 in cycle 0; port1 granted in cycle 1 after port0 drops req.
REQ-036 SHALL verify: rd_gnt_i held 0 for 5 cycles with port0 waiting and port1 raising req in cycle 2 -> rd_addr_o stays port0's address and rd_id_o=0 until the grant.
REQ-037 SHALL verify: a 4-beat burst on id 1 with data 0xA..0xD -> rtrn_valid_o[1] on 4 cycles with matching data, rtrn_last_o on beat 4, and busy_o[1] falling the next cycle.
REQ-038 SHALL verify: a beat with rd_id_i=5 at NumPorts=2 -> err_o pulses once and rtrn_valid_o=0.
REQ-039 SHALL verify: rst_i asserted for 1 cycle mid-burst -> busy_o=0, and the remaining beats produce err_o.
REQ-040 SHALL verify: port0 last beat coincides with a new port0 req -> gnt_o[0] no earlier than the next cycle.
